// File: rtl/snake_move_ctrl.sv
// Snake game-state controller: sequences idle/run/step/over, stores the body as a
// register array, advances it on game ticks and answers renderer occupancy queries.
module snake_move_ctrl #(
  parameter int GRID_COLS = 20,
  parameter int GRID_ROWS = 15,
  parameter int MAX_LEN   = 16
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Game_Tick,
  input  logic       i_Up,
  input  logic       i_Down,
  input  logic       i_Left,
  input  logic       i_Right,
  input  logic [4:0] i_Food_Col,
  input  logic [4:0] i_Food_Row,
  input  logic [4:0] i_Query_Col,
  input  logic [4:0] i_Query_Row,
  output logic       o_Query_Hit,
  output logic [4:0] o_Head_Col,
  output logic [4:0] o_Head_Row,
  output logic [4:0] o_Length,
  output logic       o_Food_Eaten,
  output logic       o_Game_Over,
  output logic [1:0] o_State
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2,
    S_OVER = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    D_UP    = 2'd0,
    D_DOWN  = 2'd1,
    D_LEFT  = 2'd2,
    D_RIGHT = 2'd3
  } dir_e;

  typedef struct packed {
    logic [4:0] col;
    logic [4:0] row;
  } cell_t;

  localparam logic [4:0] INIT_COL = 5'(GRID_COLS / 2);
  localparam logic [4:0] INIT_ROW = 5'(GRID_ROWS / 2);
  localparam logic [4:0] INIT_LEN = 5'd3;
  localparam logic [4:0] CAP_LEN  = 5'(MAX_LEN);

  function automatic cell_t init_cell(input int idx);
    cell_t c;
    c = '0;
    if (idx < 3) begin
      c.col = INIT_COL - 5'(idx);
      c.row = INIT_ROW;
    end
    return c;
  endfunction

  function automatic dir_e opposite(input dir_e d);
    dir_e o;
    unique case (d)
      D_UP:    o = D_DOWN;
      D_DOWN:  o = D_UP;
      D_LEFT:  o = D_RIGHT;
      default: o = D_LEFT;
    endcase
    return o;
  endfunction

  state_e              state_q, state_d;
  cell_t [MAX_LEN-1:0] seg_q, seg_d;
  logic [4:0]          len_q, len_d;
  dir_e                dir_q, dir_d;
  dir_e                pend_q, pend_d;
  logic                btn_q;
  logic                food_q, food_d;
  logic                hit_q, hit_d;

  logic       btn_any, any_press;
  dir_e       req_dir;
  logic [5:0] nxt_col, nxt_row;
  cell_t      nxt_cell, food_cell, query_cell;
  logic       wall_hit, self_hit, grow, collide;
  logic [4:0] chk_len;
  logic       do_move, load_init;

  assign btn_any   = i_Up | i_Down | i_Left | i_Right;
  assign any_press = btn_any & ~btn_q;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (any_press)   state_d = S_RUN;
      S_RUN:   if (i_Game_Tick) state_d = S_STEP;
      S_STEP:  state_d = collide ? S_OVER : S_RUN;
      default: if (any_press)   state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    o_State     = state_q;
    o_Game_Over = (state_q == S_OVER);
    o_Head_Col  = seg_q[0].col;
    o_Head_Row  = seg_q[0].row;
    o_Length    = len_q;
  end

  assign o_Food_Eaten = food_q;
  assign o_Query_Hit  = hit_q;

  assign do_move   = (state_q == S_STEP) && !collide;
  assign load_init = (state_q == S_OVER) && any_press;

  // Direction arbitration: highest-priority held button, rejected if it reverses the last move.
  always_comb begin
    req_dir = D_RIGHT;
    if (i_Up)        req_dir = D_UP;
    else if (i_Down) req_dir = D_DOWN;
    else if (i_Left) req_dir = D_LEFT;

    pend_d = pend_q;
    if (load_init)
      pend_d = D_RIGHT;
    else if ((state_q == S_RUN) && btn_any && (req_dir != opposite(dir_q)))
      pend_d = req_dir;
  end

  // Next head carries one extra bit so a step off column/row 0 underflows past the limit.
  always_comb begin
    nxt_col = {1'b0, seg_q[0].col};
    nxt_row = {1'b0, seg_q[0].row};
    unique case (pend_q)
      D_UP:    nxt_row = nxt_row - 6'd1;
      D_DOWN:  nxt_row = nxt_row + 6'd1;
      D_LEFT:  nxt_col = nxt_col - 6'd1;
      default: nxt_col = nxt_col + 6'd1;
    endcase
  end

  assign nxt_cell   = {nxt_col[4:0], nxt_row[4:0]};
  assign food_cell  = {i_Food_Col, i_Food_Row};
  assign query_cell = {i_Query_Col, i_Query_Row};
  assign wall_hit   = (nxt_col >= 6'(GRID_COLS)) || (nxt_row >= 6'(GRID_ROWS));
  assign grow       = (nxt_cell == food_cell);

  // The tail cell only counts as an obstacle when it will not vacate (growth move).
  always_comb begin
    chk_len  = grow ? len_q : (len_q - 5'd1);
    self_hit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((5'(i) < chk_len) && (seg_q[i] == nxt_cell)) self_hit = 1'b1;
    end
  end

  assign collide = wall_hit | self_hit;

  // Body, length and committed direction update.
  always_comb begin
    seg_d  = seg_q;
    len_d  = len_q;
    dir_d  = dir_q;
    food_d = 1'b0;
    if (load_init) begin
      for (int i = 0; i < MAX_LEN; i++) seg_d[i] = init_cell(i);
      len_d = INIT_LEN;
      dir_d = D_RIGHT;
    end else if (do_move) begin
      seg_d[0] = nxt_cell;
      for (int i = 1; i < MAX_LEN; i++) seg_d[i] = seg_q[i-1];
      dir_d  = pend_q;
      food_d = grow;
      if (grow && (len_q < CAP_LEN)) len_d = len_q + 5'd1;
    end
  end

  always_comb begin
    hit_d = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((5'(i) < len_q) && (seg_q[i] == query_cell)) hit_d = 1'b1;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      // NOTE: the body array is reset, not just the length, because the init image must be visible at once.
      for (int i = 0; i < MAX_LEN; i++) seg_q[i] <= init_cell(i);
      len_q  <= INIT_LEN;
      dir_q  <= D_RIGHT;
      pend_q <= D_RIGHT;
      // Starting high means a button held through reset produces no press edge.
      btn_q  <= 1'b1;
      food_q <= 1'b0;
      hit_q  <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      seg_q  <= seg_d;
      len_q  <= len_d;
      dir_q  <= dir_d;
      pend_q <= pend_d;
      btn_q  <= btn_any;
      food_q <= food_d;
      hit_q  <= hit_d;
    end
  end

endmodule

// File: tb/tb_snake_move_ctrl.sv
// Self-checking bench for snake_move_ctrl: directed scenarios plus randomized games
// compared against a queue-based game model.
module tb_snake_move_ctrl;

  logic       i_Clk = 1'b0;
  logic       i_Rst_L = 1'b0;
  logic       i_Game_Tick = 1'b0;
  logic       i_Up = 1'b0, i_Down = 1'b0, i_Left = 1'b0, i_Right = 1'b0;
  logic [4:0] i_Food_Col = 5'd0, i_Food_Row = 5'd0;
  logic [4:0] i_Query_Col = 5'd0, i_Query_Row = 5'd0;
  logic       o_Query_Hit;
  logic [4:0] o_Head_Col, o_Head_Row, o_Length;
  logic       o_Food_Eaten, o_Game_Over;
  logic [1:0] o_State;

  snake_move_ctrl dut (
    .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Game_Tick(i_Game_Tick),
    .i_Up(i_Up), .i_Down(i_Down), .i_Left(i_Left), .i_Right(i_Right),
    .i_Food_Col(i_Food_Col), .i_Food_Row(i_Food_Row),
    .i_Query_Col(i_Query_Col), .i_Query_Row(i_Query_Row),
    .o_Query_Hit(o_Query_Hit), .o_Head_Col(o_Head_Col), .o_Head_Row(o_Head_Row),
    .o_Length(o_Length), .o_Food_Eaten(o_Food_Eaten), .o_Game_Over(o_Game_Over),
    .o_State(o_State)
  );

  always #5 i_Clk = ~i_Clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Game model: body as queues (index 0 = head); directions 0=up 1=down 2=left 3=right.
  int bc[$];
  int br[$];
  int m_dir, m_pend, m_state;   // m_state: 0 idle, 1 run, 3 over
  int food_c, food_r;

  localparam int M_UP = 8, M_DOWN = 4, M_LEFT = 2, M_RIGHT = 1;

  function automatic int opp(input int d);
    case (d)
      0: return 1;
      1: return 0;
      2: return 3;
      default: return 2;
    endcase
  endfunction

  task automatic model_init();
    bc = {10, 9, 8};
    br = {7, 7, 7};
    m_dir = 3; m_pend = 3; m_state = 0;
  endtask

  task automatic model_arb(input int mask);
    int req;
    if (m_state != 1 || mask == 0) return;
    if (mask[3])      req = 0;
    else if (mask[2]) req = 1;
    else if (mask[1]) req = 2;
    else              req = 3;
    if (req != opp(m_dir)) m_pend = req;
  endtask

  task automatic model_move(output bit ate);
    int nc, nr, lim;
    bit wall, grow, self_c;
    nc = bc[0]; nr = br[0];
    case (m_pend)
      0: nr = nr - 1;
      1: nr = nr + 1;
      2: nc = nc - 1;
      default: nc = nc + 1;
    endcase
    wall = (nc < 0) || (nc >= 20) || (nr < 0) || (nr >= 15);
    grow = !wall && (nc == food_c) && (nr == food_r);
    lim  = grow ? bc.size() : bc.size() - 1;
    self_c = 0;
    for (int k = 0; k < lim; k++) if (bc[k] == nc && br[k] == nr) self_c = 1;
    ate = 0;
    if (wall || self_c) begin
      m_state = 3;
    end else begin
      bc.push_front(nc); br.push_front(nr);
      if (!grow || bc.size() > 16) begin
        void'(bc.pop_back()); void'(br.pop_back());
      end
      m_dir = m_pend;
      ate = grow;
    end
  endtask

  function automatic bit model_has(input int c, input int r);
    for (int k = 0; k < bc.size(); k++) if (bc[k] == c && br[k] == r) return 1;
    return 0;
  endfunction

  task automatic set_btn(input int mask);
    {i_Up, i_Down, i_Left, i_Right} = 4'(mask);
  endtask

  task automatic set_food(input int c, input int r);
    food_c = c; food_r = r;
    i_Food_Col = 5'(c); i_Food_Row = 5'(r);
  endtask

  task automatic apply_reset();
    set_btn(0);
    i_Game_Tick = 1'b0;
    i_Rst_L = 1'b0;
    repeat (2) @(negedge i_Clk);
    i_Rst_L = 1'b1;
    @(negedge i_Clk);
    model_init();
  endtask

  task automatic start_game(input int mask);
    set_btn(mask);
    @(negedge i_Clk);
    n_tests++;
    if (o_State !== 2'd1) begin
      n_fail++; $display("FAIL start: state got %0d expected 1", o_State);
    end
    m_state = 1;
    @(negedge i_Clk);
    model_arb(mask);
    set_btn(0);
    @(negedge i_Clk);
  endtask

  task automatic hold(input int mask);
    set_btn(mask);
    @(negedge i_Clk);
    model_arb(mask);
    set_btn(0);
    @(negedge i_Clk);
  endtask

  // Tick with buttons applied in the same RUN cycle; checks STEP, the move result and the pulse width.
  task automatic do_tick(input int mask, input string tag);
    bit ate;
    set_btn(mask);
    i_Game_Tick = 1'b1;
    @(negedge i_Clk);
    i_Game_Tick = 1'b0;
    set_btn(0);
    n_tests++;
    if (o_State !== 2'd2) begin
      n_fail++; $display("FAIL %s step_state: got %0d expected 2", tag, o_State);
    end
    model_arb(mask);
    model_move(ate);
    @(negedge i_Clk);
    n_tests++;
    if (o_Head_Col !== 5'(bc[0]) || o_Head_Row !== 5'(br[0])) begin
      n_fail++;
      $display("FAIL %s head: got (%0d,%0d) expected (%0d,%0d)", tag, o_Head_Col, o_Head_Row, bc[0], br[0]);
    end
    n_tests++;
    if (o_Length !== 5'(bc.size())) begin
      n_fail++; $display("FAIL %s length: got %0d expected %0d", tag, o_Length, bc.size());
    end
    n_tests++;
    if (o_Food_Eaten !== ate) begin
      n_fail++; $display("FAIL %s food_eaten: got %0b expected %0b", tag, o_Food_Eaten, ate);
    end
    n_tests++;
    if (o_Game_Over !== (m_state == 3) || o_State !== 2'(m_state)) begin
      n_fail++;
      $display("FAIL %s state: got state %0d over %0b expected state %0d", tag, o_State, o_Game_Over, m_state);
    end
    @(negedge i_Clk);
    n_tests++;
    if (o_Food_Eaten !== 1'b0) begin
      n_fail++; $display("FAIL %s food_pulse_width: got %0b expected 0", tag, o_Food_Eaten);
    end
  endtask

  task automatic query(input int c, input int r, input string tag);
    bit exp;
    i_Query_Col = 5'(c);
    i_Query_Row = 5'(r);
    exp = model_has(c, r);
    @(negedge i_Clk);
    n_tests++;
    if (o_Query_Hit !== exp) begin
      n_fail++; $display("FAIL %s query(%0d,%0d): got %0b expected %0b", tag, c, r, o_Query_Hit, exp);
    end
  endtask

  task automatic press_restart(input int mask);
    set_btn(mask);
    @(negedge i_Clk);
    n_tests++;
    if (o_State !== 2'd0 || o_Game_Over !== 1'b0 || o_Head_Col !== 5'd10 ||
        o_Head_Row !== 5'd7 || o_Length !== 5'd3) begin
      n_fail++;
      $display("FAIL restart: state %0d over %0b head (%0d,%0d) len %0d expected 0 0 (10,7) 3",
               o_State, o_Game_Over, o_Head_Col, o_Head_Row, o_Length);
    end
    set_btn(0);
    @(negedge i_Clk);
    model_init();
  endtask

  task automatic test_reset();
    set_btn(M_UP);               // held through reset: must not start the game
    i_Rst_L = 1'b0;
    repeat (2) @(negedge i_Clk);
    n_tests++;
    if (o_State !== 2'd0 || o_Length !== 5'd3 || o_Head_Col !== 5'd10 || o_Head_Row !== 5'd7 ||
        o_Game_Over !== 1'b0 || o_Food_Eaten !== 1'b0 || o_Query_Hit !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: state %0d len %0d head (%0d,%0d) over %0b food %0b hit %0b",
               o_State, o_Length, o_Head_Col, o_Head_Row, o_Game_Over, o_Food_Eaten, o_Query_Hit);
    end
    i_Rst_L = 1'b1;
    repeat (3) @(negedge i_Clk);
    n_tests++;
    if (o_State !== 2'd0) begin
      n_fail++; $display("FAIL held_button_through_reset: state got %0d expected 0", o_State);
    end
    set_btn(0);
    @(negedge i_Clk);
    model_init();
    query(10, 7, "reset");
    query(9, 7, "reset");
    query(8, 7, "reset");
    query(7, 7, "reset");
    query(25, 7, "reset_oob");
  endtask

  task automatic test_dropped_ticks();
    apply_reset();
    set_food(0, 0);
    i_Game_Tick = 1'b1;
    @(negedge i_Clk);
    i_Game_Tick = 1'b0;
    @(negedge i_Clk);
    n_tests++;
    if (o_State !== 2'd0 || o_Head_Col !== 5'd10) begin
      n_fail++; $display("FAIL idle_tick: state %0d head_col %0d expected 0 10", o_State, o_Head_Col);
    end
    start_game(M_RIGHT);
    // Two-cycle tick: the second cycle lands in STEP and is dropped.
    i_Game_Tick = 1'b1;
    repeat (2) @(negedge i_Clk);
    i_Game_Tick = 1'b0;
    repeat (2) @(negedge i_Clk);
    n_tests++;
    if (o_Head_Col !== 5'd11 || o_State !== 2'd1) begin
      n_fail++; $display("FAIL step_tick_dropped: head_col %0d state %0d expected 11 1", o_Head_Col, o_State);
    end
    bc = {11, 10, 9}; br = {7, 7, 7};
    do_tick(0, "back_to_back");
  endtask

  task automatic test_wall();
    apply_reset();
    set_food(0, 0);
    start_game(M_RIGHT);
    for (int t = 0; t < 9; t++) do_tick(0, "wall_run");
    n_tests++;
    if (o_Head_Col !== 5'd19 || o_Head_Row !== 5'd7) begin
      n_fail++; $display("FAIL wall_edge_head: got (%0d,%0d) expected (19,7)", o_Head_Col, o_Head_Row);
    end
    do_tick(0, "wall_hit");
    n_tests++;
    if (o_Game_Over !== 1'b1 || o_Head_Col !== 5'd19 || o_Length !== 5'd3) begin
      n_fail++;
      $display("FAIL wall_over: over %0b head_col %0d len %0d expected 1 19 3", o_Game_Over, o_Head_Col, o_Length);
    end
    press_restart(M_DOWN);
  endtask

  task automatic test_reversal();
    apply_reset();
    set_food(0, 0);
    start_game(M_RIGHT);
    do_tick(M_LEFT, "reverse_left");
    hold(M_UP);
    do_tick(0, "turn_up");
    do_tick(M_DOWN, "reverse_down");
    n_tests++;
    if (o_Head_Col !== 5'd11 || o_Head_Row !== 5'd5) begin
      n_fail++; $display("FAIL reversal_head: got (%0d,%0d) expected (11,5)", o_Head_Col, o_Head_Row);
    end
  endtask

  task automatic test_food();
    apply_reset();
    start_game(M_RIGHT);
    set_food(11, 7);
    do_tick(0, "eat_first");
    query(8, 7, "tail_kept");
    for (int c = 12; c <= 19; c++) begin
      set_food(c, 7);
      do_tick(0, "eat_right");
    end
    for (int r = 6; r >= 3; r--) begin
      set_food(19, r);
      do_tick(M_UP, "eat_up");
    end
    n_tests++;
    if (o_Length !== 5'd16) begin
      n_fail++; $display("FAIL length_16: got %0d expected 16", o_Length);
    end
    set_food(19, 2);
    do_tick(0, "eat_at_cap");
    n_tests++;
    if (o_Length !== 5'd16) begin
      n_fail++; $display("FAIL length_saturate: got %0d expected 16", o_Length);
    end
    query(bc[15], br[15], "cap_tail");
    query(9, 7, "cap_dropped");
    query(19, 2, "cap_head");
  endtask

  task automatic test_self_collision();
    apply_reset();
    start_game(M_RIGHT);
    set_food(11, 7);
    do_tick(0, "self_grow1");
    set_food(12, 7);
    do_tick(0, "self_grow2");
    set_food(0, 0);
    do_tick(M_UP, "self_up");
    do_tick(M_LEFT, "self_left");
    do_tick(M_DOWN, "self_down");
    n_tests++;
    if (o_Game_Over !== 1'b1 || o_Length !== 5'd5) begin
      n_fail++; $display("FAIL self_over: over %0b len %0d expected 1 5", o_Game_Over, o_Length);
    end
    press_restart(M_LEFT);
    query(10, 7, "restored");
    query(8, 7, "restored");
    query(12, 6, "restored");
  endtask

  task automatic test_async_reset_step();
    apply_reset();
    set_food(11, 7);
    start_game(M_RIGHT);
    i_Game_Tick = 1'b1;
    @(negedge i_Clk);
    i_Game_Tick = 1'b0;
    i_Rst_L = 1'b0;
    #1;
    n_tests++;
    if (o_State !== 2'd0 || o_Head_Col !== 5'd10 || o_Head_Row !== 5'd7 || o_Length !== 5'd3 ||
        o_Game_Over !== 1'b0 || o_Food_Eaten !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: state %0d head (%0d,%0d) len %0d over %0b food %0b",
               o_State, o_Head_Col, o_Head_Row, o_Length, o_Game_Over, o_Food_Eaten);
    end
    @(negedge i_Clk);
    i_Rst_L = 1'b1;
    repeat (2) @(negedge i_Clk);
    model_init();
    n_tests++;
    if (o_State !== 2'd0 || o_Head_Col !== 5'd10 || o_Length !== 5'd3 || o_Food_Eaten !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_after: state %0d head_col %0d len %0d food %0b",
               o_State, o_Head_Col, o_Length, o_Food_Eaten);
    end
    query(11, 7, "no_partial_move");
  endtask

  task automatic test_random();
    int nc, nr, mask;
    for (int g = 0; g < 8; g++) begin
      apply_reset();
      set_food($urandom_range(19), $urandom_range(14));
      start_game($urandom_range(15, 1));
      for (int t = 0; t < 40 && m_state == 1; t++) begin
        if ($urandom_range(2) == 0) hold($urandom_range(15, 1));
        nc = bc[0]; nr = br[0];
        case (m_pend)
          0: nr--;
          1: nr++;
          2: nc--;
          default: nc++;
        endcase
        if ($urandom_range(1) == 0 && nc >= 0 && nc < 20 && nr >= 0 && nr < 15) set_food(nc, nr);
        else set_food($urandom_range(19), $urandom_range(14));
        mask = ($urandom_range(3) == 0) ? $urandom_range(15) : 0;
        do_tick(mask, "random");
        if ($urandom_range(1) == 0) begin
          int k;
          k = $urandom_range(bc.size() - 1);
          query(bc[k], br[k], "random_body");
        end else begin
          query($urandom_range(31), $urandom_range(31), "random_any");
        end
      end
      if (m_state == 3) press_restart($urandom_range(15, 1));
    end
  endtask

  initial begin
    model_init();
    set_food(0, 0);
    test_reset();
    test_dropped_ticks();
    test_wall();
    test_reversal();
    test_food();
    test_self_collision();
    test_async_reset_step();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/snake_move_ctrl.md
# snake_move_ctrl

Game-state controller for the Snake design. It sits between the debounced direction buttons and the game tick on one side, and the renderer on the other. It sequences the game through idle, run and game-over phases. It holds the snake body as a register array of grid cells and advances it one cell per game tick, applying direction arbitration, growth on food, and wall/self-collision detection. It also answers per-cell occupancy queries from the renderer with one-cycle latency.

## Interface
- GRID_COLS, 20: playfield width in cells (640/32); legal columns 0..GRID_COLS-1
- GRID_ROWS, 15: playfield height in cells (480/32); legal rows 0..GRID_ROWS-1
- MAX_LEN, 16: body segment capacity; length saturates here
- i_Clk  in  1  system clock; the only clock
- i_Rst_L  in  1  reset, asynchronous, active-low
- i_Game_Tick  in  1  single-cycle move strobe, synchronous to i_Clk
- i_Up, i_Down, i_Left, i_Right  in  1 each  debounced button levels, active-high
- i_Food_Col  in  5  food cell column; i_Food_Row  in  5  food cell row
- i_Query_Col  in  5  renderer cell column; i_Query_Row  in  5  renderer cell row
- o_Query_Hit  out  1  registered; query cell is an occupied body segment
- o_Head_Col  out  5  head column; o_Head_Row  out  5  head row
- o_Length  out  5  current segment count, 3..MAX_LEN
- o_Food_Eaten  out  1  one-cycle pulse after a growth move
- o_Game_Over  out  1  high while in OVER
- o_State  out  2  IDLE=0, RUN=1, STEP=2, OVER=3

## Operation
- Body storage: seg[0..MAX_LEN-1] holds {col,row}. seg[0] is the head. Segments with index >= length are don't-care.
- Init image on reset and on OVER->IDLE: head (GRID_COLS/2, GRID_ROWS/2) = (10,7), seg1=(9,7), seg2=(8,7), length 3, committed and pending direction = Right.
- Button edge detect: any_press = rising edge of OR of the four buttons, taken from a one-cycle registered copy.
- IDLE: on any_press -> RUN. Ticks are ignored.
- RUN: on i_Game_Tick -> STEP.
  - Every cycle in RUN, arbitrate the pending direction from the buttons held high.
  - Priority is Up > Down > Left > Right.
  - A request opposite to the committed direction (the direction of the last executed move) is rejected, and pending is unchanged.
- STEP (one cycle): compute next head from the committed head and pending direction.
  - Wall: next col/row outside the legal range is a collision. Col 0 moving Left and row 0 moving Up are collisions, not wrap-around. Compute with one extra bit so underflow is detected.
  - grow = (next head == food).
  - Self: next head equals seg[i] for any i < length-1. When grow, also include i = length-1, since the tail does not vacate.
  - On collision: body, length and direction are unchanged; -> OVER.
  - Otherwise:
    - seg[i+1] <= seg[i] for all i, and seg[0] <= next head.
    - committed <= pending.
    - If grow: length <= min(length+1, MAX_LEN), and pulse o_Food_Eaten.
    - -> RUN.
  - At length MAX_LEN, grow still pulses o_Food_Eaten but the length does not change (the tail drops).
- OVER: o_Game_Over=1. Ticks and direction inputs are ignored. On any_press, load the init image -> IDLE.
- Query: o_Query_Hit <= OR over i<length of (seg[i]=={i_Query_Col,i_Query_Row}). Out-of-range queries give 0.

## Timing
- Reset values:
  - State IDLE, o_State=0, o_Game_Over=0, o_Food_Eaten=0, o_Query_Hit=0.
  - o_Length=3, o_Head_Col=10, o_Head_Row=7, direction Right.
  - Reset asserted mid-STEP or mid-game returns to these values immediately (asynchronously); no partial move is retained.
- Tick sampled at edge T in RUN: state=STEP during T+1; body/length/state update at end of T+1; new head, o_Food_Eaten, o_Game_Over visible from T+2.
- o_Food_Eaten is high for exactly the one cycle T+2.
- A tick arriving during STEP, IDLE or OVER is dropped; there is no queuing.
- A tick and a button change in the same RUN cycle: the arbitration result written that cycle is used in STEP.
- Query latency is exactly 1 cycle and reflects the body state at the sampling edge.
- any_press: a button held through reset does not generate an edge until it is released and pressed again.

## Test plan
- Reset and query: release reset, query (10,7), (9,7), (8,7), (7,7) -> hit 1,1,1,0 one cycle after each; o_Length=3, o_State=0.
- Wall: press Right, then 9 ticks -> head (19,7); 10th tick -> o_Game_Over=1 at T+2, head stays (19,7), length 3.
- Reversal: in RUN with direction Right, hold Left and tick -> head (11,7), i.e. Left is rejected. Then Up + tick -> (11,6). Then Down + tick -> (11,5), i.e. Down is rejected as the reverse of Up.
- Food: food at (11,7), tick -> o_Food_Eaten pulse of 1 cycle, length 4, tail (8,7) is still hit. At length 16, eating keeps length 16 and still pulses.
- Self-collision: grow to length 5, then moves Up, Left, Down -> OVER on the Down tick. Press any button -> IDLE with the init image restored.
- Async reset during STEP (assert i_Rst_L=0 for 1 cycle at T+1) -> all reset values, no body shift.
